// File: rtl/fabric_temporal_pe_rf.sv
// Temporal PE: tag-dispatched instruction memory, built-in ALU, operands/results via ports or register FIFOs.
// Latency: 1 cycle from input handshake to registered output; register FIFO pushes are visible the next cycle.
// Backpressure: an instruction fires only when every source is present and every enabled destination can accept.
module fabric_temporal_pe_rf #(
    parameter int NUM_INPUTS       = 2,
    parameter int NUM_OUTPUTS      = 1,
    parameter int DATA_WIDTH       = 32,
    parameter int TAG_WIDTH        = 4,
    parameter int NUM_REGISTERS    = 2,
    parameter int REG_FIFO_DEPTH   = 2,
    parameter int NUM_INSTRUCTIONS = 4,
    localparam int RB = (NUM_REGISTERS > 0) ?
                        1 + $clog2((NUM_REGISTERS < 2) ? 2 : NUM_REGISTERS) : 0,
    localparam int INSN_WIDTH = 1 + TAG_WIDTH + 3 + NUM_INPUTS * RB +
                                NUM_OUTPUTS * (1 + RB + TAG_WIDTH)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_INPUTS-1:0]                       in_valid,
    output logic [NUM_INPUTS-1:0]                       in_ready,
    input  logic [NUM_INPUTS*(DATA_WIDTH+TAG_WIDTH)-1:0] in_data,
    output logic [NUM_OUTPUTS-1:0]                      out_valid,
    input  logic [NUM_OUTPUTS-1:0]                      out_ready,
    output logic [NUM_OUTPUTS*(DATA_WIDTH+TAG_WIDTH)-1:0] out_data,
    input  logic [NUM_INSTRUCTIONS*INSN_WIDTH-1:0]      cfg_data,
    output logic                                        error_valid,
    output logic [15:0]                                 error_code
);

    localparam int DW   = DATA_WIDTH;
    localparam int TW   = TAG_WIDTH;
    localparam int IW   = INSN_WIDTH;
    localparam int TKW  = DW + TW;
    localparam int RIW  = (RB > 1) ? RB - 1 : 1;
    localparam int SRCB = (RB > 0) ? RB - 1 : 0;
    localparam int DSTW = 1 + RB + TW;
    localparam int SRC_OFF = NUM_OUTPUTS * DSTW;
    localparam int OP_OFF  = SRC_OFF + NUM_INPUTS * RB;
    localparam int TAG_OFF = OP_OFF + 3;
    localparam int NRX  = (NUM_REGISTERS > 0) ? NUM_REGISTERS : 1;
    localparam int PW   = (REG_FIFO_DEPTH > 1) ? $clog2(REG_FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(REG_FIFO_DEPTH + 1);

    // Error codes: configuration faults rank ahead of runtime faults.
    localparam logic [15:0] CFG_TEMPORAL_PE_DUP_TAG         = 16'h0001;
    localparam logic [15:0] CFG_TEMPORAL_PE_ILLEGAL_REG     = 16'h0002;
    localparam logic [15:0] CFG_TEMPORAL_PE_REG_TAG_NONZERO = 16'h0003;
    localparam logic [15:0] RT_TEMPORAL_PE_NO_MATCH         = 16'h0100;

    // ---------------- field extraction helpers ----------------
    function automatic logic bit_at(input logic [IW-1:0] w, input int n);
        return ((w >> n) & IW'(1)) != '0;
    endfunction

    function automatic logic [IW-1:0] insn_at(input logic [NUM_INSTRUCTIONS*IW-1:0] cfg,
                                              input int i);
        return IW'(cfg >> (i * IW));
    endfunction

    function automatic logic f_valid(input logic [IW-1:0] w);
        return w[IW-1];
    endfunction

    function automatic logic [TW-1:0] f_tag(input logic [IW-1:0] w);
        return TW'(w >> TAG_OFF);
    endfunction

    function automatic logic [2:0] f_op(input logic [IW-1:0] w);
        return 3'(w >> OP_OFF);
    endfunction

    function automatic logic src_is_reg(input logic [IW-1:0] w, input int k);
        return (RB > 0) && bit_at(w, SRC_OFF + k * RB + SRCB);
    endfunction

    function automatic logic [RIW-1:0] src_ridx(input logic [IW-1:0] w, input int k);
        return RIW'(w >> (SRC_OFF + k * RB));
    endfunction

    function automatic logic dst_en(input logic [IW-1:0] w, input int j);
        return bit_at(w, j * DSTW + TW + RB);
    endfunction

    function automatic logic dst_is_reg(input logic [IW-1:0] w, input int j);
        return (RB > 0) && bit_at(w, j * DSTW + TW + SRCB);
    endfunction

    function automatic logic [RIW-1:0] dst_ridx(input logic [IW-1:0] w, input int j);
        return RIW'(w >> (j * DSTW + TW));
    endfunction

    function automatic logic [TW-1:0] dst_tag(input logic [IW-1:0] w, input int j);
        return TW'(w >> (j * DSTW));
    endfunction

    function automatic logic [DW-1:0] tok_val(
        input logic [NUM_INPUTS*TKW-1:0] bus, input int k);
        return DW'(bus >> (k * TKW));
    endfunction

    function automatic logic [TW-1:0] tok_tag(
        input logic [NUM_INPUTS*TKW-1:0] bus, input int k);
        return TW'(bus >> (k * TKW + DW));
    endfunction

    // ---------------- state ----------------
    logic [DW-1:0] mem  [NRX][REG_FIFO_DEPTH];
    logic [PW-1:0] rptr [NRX];
    logic [PW-1:0] wptr [NRX];
    logic [CW-1:0] cnt  [NRX];
    logic [DW-1:0] head [NRX];

    // ---------------- combinational datapath ----------------
    logic [TW-1:0]          key_tag;
    logic                   match;
    logic [IW-1:0]          sel_w;
    logic [DW-1:0]          opnd [NUM_INPUTS];
    logic [DW-1:0]          op_b;
    logic [DW-1:0]          result;
    logic                   srcs_rdy;
    logic                   dsts_rdy;
    logic                   fire;
    logic [NRX-1:0]         pop_req;
    logic [NRX-1:0]         push_req;
    logic [NRX-1:0]         pop_fire;
    logic [NRX-1:0]         push_fire;
    logic [NUM_OUTPUTS-1:0] load_req;
    logic                   err_dup;
    logic                   err_ill;
    logic                   err_nz;
    logic                   err_nomatch;
    logic                   err_any;
    logic [15:0]            err_code_now;

    // FIFO heads: the oldest entry of each register FIFO.
    always_comb begin
        for (int r = 0; r < NRX; r++) begin
            head[r] = mem[r][rptr[r]];
        end
    end

    // Dispatch: lowest-indexed valid instruction whose tag equals port 0's tag.
    always_comb begin
        key_tag = tok_tag(in_data, 0);
        match   = 1'b0;
        sel_w   = '0;
        for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
            if (!match && f_valid(insn_at(cfg_data, i)) &&
                f_tag(insn_at(cfg_data, i)) == key_tag) begin
                match = 1'b1;
                sel_w = insn_at(cfg_data, i);
            end
        end
    end

    // Operand gathering and source readiness; operand 0 is always port 0.
    always_comb begin
        srcs_rdy = in_valid[0];
        pop_req  = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            opnd[k] = tok_val(in_data, k);
        end
        for (int k = 1; k < NUM_INPUTS; k++) begin
            if (src_is_reg(sel_w, k)) begin
                if (int'(src_ridx(sel_w, k)) < NUM_REGISTERS) begin
                    opnd[k] = head[src_ridx(sel_w, k)];
                    pop_req[src_ridx(sel_w, k)] = 1'b1;
                    if (cnt[src_ridx(sel_w, k)] == '0) begin
                        srcs_rdy = 1'b0;
                    end
                end else begin
                    srcs_rdy = 1'b0;
                end
            end else if (!in_valid[k]) begin
                srcs_rdy = 1'b0;
            end
        end
    end

    // ALU, all arithmetic modulo 2^DATA_WIDTH.
    always_comb begin
        op_b = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (k == 1) begin
                op_b = opnd[k];
            end
        end
        case (f_op(sel_w))
            3'd1:    result = opnd[0] + op_b;
            3'd2:    result = opnd[0] - op_b;
            3'd3:    result = opnd[0] & op_b;
            3'd4:    result = opnd[0] | op_b;
            3'd5:    result = opnd[0] ^ op_b;
            3'd6:    result = (opnd[0] < op_b) ? opnd[0] : op_b;
            default: result = opnd[0];
        endcase
    end

    // Destination acceptance; a FIFO popped this cycle may take a push even when full.
    always_comb begin
        dsts_rdy = 1'b1;
        push_req = '0;
        load_req = '0;
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            if (dst_en(sel_w, j)) begin
                if (dst_is_reg(sel_w, j)) begin
                    if (int'(dst_ridx(sel_w, j)) < NUM_REGISTERS) begin
                        push_req[dst_ridx(sel_w, j)] = 1'b1;
                        if (cnt[dst_ridx(sel_w, j)] == CW'(REG_FIFO_DEPTH) &&
                            !pop_req[dst_ridx(sel_w, j)]) begin
                            dsts_rdy = 1'b0;
                        end
                    end else begin
                        dsts_rdy = 1'b0;
                    end
                end else begin
                    load_req[j] = 1'b1;
                    if (out_valid[j] && !out_ready[j]) begin
                        dsts_rdy = 1'b0;
                    end
                end
            end
        end
    end

    // Fire decision and input handshakes; register-sourced ports are left untouched.
    always_comb begin
        fire      = match && srcs_rdy && dsts_rdy;
        pop_fire  = pop_req & {NRX{fire}};
        push_fire = push_req & {NRX{fire}};
        for (int k = 0; k < NUM_INPUTS; k++) begin
            in_ready[k] = fire && (k == 0 || !src_is_reg(sel_w, k));
        end
    end

    // Error detection; the lowest-numbered active code is reported.
    always_comb begin
        err_dup     = 1'b0;
        err_ill     = 1'b0;
        err_nz      = 1'b0;
        err_nomatch = in_valid[0] && !match;
        for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
            if (f_valid(insn_at(cfg_data, i))) begin
                for (int i2 = i + 1; i2 < NUM_INSTRUCTIONS; i2++) begin
                    if (f_valid(insn_at(cfg_data, i2)) &&
                        f_tag(insn_at(cfg_data, i2)) == f_tag(insn_at(cfg_data, i))) begin
                        err_dup = 1'b1;
                    end
                end
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    if (src_is_reg(insn_at(cfg_data, i), k) &&
                        int'(src_ridx(insn_at(cfg_data, i), k)) >= NUM_REGISTERS) begin
                        err_ill = 1'b1;
                    end
                end
                for (int j = 0; j < NUM_OUTPUTS; j++) begin
                    if (dst_en(insn_at(cfg_data, i), j) && dst_is_reg(insn_at(cfg_data, i), j)) begin
                        if (int'(dst_ridx(insn_at(cfg_data, i), j)) >= NUM_REGISTERS) begin
                            err_ill = 1'b1;
                        end
                        if (dst_tag(insn_at(cfg_data, i), j) != '0) begin
                            err_nz = 1'b1;
                        end
                    end
                end
            end
        end
        err_any = err_dup || err_ill || err_nz || err_nomatch;
        if (err_dup) begin
            err_code_now = CFG_TEMPORAL_PE_DUP_TAG;
        end else if (err_ill) begin
            err_code_now = CFG_TEMPORAL_PE_ILLEGAL_REG;
        end else if (err_nz) begin
            err_code_now = CFG_TEMPORAL_PE_REG_TAG_NONZERO;
        end else if (err_nomatch) begin
            err_code_now = RT_TEMPORAL_PE_NO_MATCH;
        end else begin
            err_code_now = '0;
        end
    end

    // ---------------- sequential ----------------
    // Register FIFO storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NRX; r++) begin
            if (push_fire[r]) begin
                mem[r][wptr[r]] <= result;
            end
        end
    end

    // Register FIFO pointers and occupancy; simultaneous push+pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NRX; r++) begin
                rptr[r] <= '0;
                wptr[r] <= '0;
                cnt[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NRX; r++) begin
                if (push_fire[r]) begin
                    wptr[r] <= (wptr[r] == PW'(REG_FIFO_DEPTH - 1)) ? '0 : wptr[r] + PW'(1);
                end
                if (pop_fire[r]) begin
                    rptr[r] <= (rptr[r] == PW'(REG_FIFO_DEPTH - 1)) ? '0 : rptr[r] + PW'(1);
                end
                if (push_fire[r] && !pop_fire[r]) begin
                    cnt[r] <= cnt[r] + CW'(1);
                end else if (!push_fire[r] && pop_fire[r]) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    // Output registers: load on fire, otherwise hold until the consumer takes the token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                if (fire && load_req[j]) begin
                    out_valid[j]               <= 1'b1;
                    out_data[j * TKW +: TKW]   <= {dst_tag(sel_w, j), result};
                end else if (out_ready[j]) begin
                    out_valid[j] <= 1'b0;
                end
            end
        end
    end

    // Sticky first-error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_valid <= 1'b0;
            error_code  <= '0;
        end else if (!error_valid && err_any) begin
            error_valid <= 1'b1;
            error_code  <= err_code_now;
        end
    end

endmodule
